waveform_to_pipe_bram: RTL

Capture path for host readback, the counterpart of the pipe-in waveform block. Once per simulation tick it samples a 32-bit value (muscle force, spike count, etc.) into an on-chip FIFO. It then streams the FIFO contents to the host as 16-bit halfwords through the block-throttled pipe-out endpoint. The block runs entirely in the host-interface clock domain; the simulation tick enters as an asynchronous level and is synchronized inside.

---
 rtl/waveform_to_pipe_bram_pkg.sv | 13 +
 rtl/waveform_to_pipe_bram_sdp_bram.sv | 38 +++
 rtl/waveform_to_pipe_bram.sv | 133 +++++++++++++
 3 files changed

// File: rtl/waveform_to_pipe_bram_pkg.sv
// Shared constants for the waveform capture/playback blocks.
//   DATA_W                 sample width in bits
//   HALF_W                 host pipe word width in bits
//   DEFAULT_DEPTH_LOG2     default FIFO depth (log2, in samples)
//   DEFAULT_BLOCK_SAMPLES  samples per host block (512 halfwords)
package waveform_to_pipe_bram_pkg;

   localparam int unsigned DATA_W                = 32;
   localparam int unsigned HALF_W                = 16;
   localparam int unsigned DEFAULT_DEPTH_LOG2    = 10;
   localparam int unsigned DEFAULT_BLOCK_SAMPLES = 256;

endpackage

// File: rtl/waveform_to_pipe_bram_sdp_bram.sv
// Simple dual-port RAM, 2^ADDR_W x WIDTH, single clock.
// Ports:
//   clk      clock for both ports
//   wr_en    write strobe; wr_data stored at wr_addr on the rising edge
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data loads mem[rd_addr] on the rising edge
//   rd_addr  read address
//   rd_data  registered read data, holds while rd_en is low
// Reads return the old contents when the same address is written in the same
// cycle (read-first). No reset so the array maps onto block RAM.
module sdp_bram
   import waveform_to_pipe_bram_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_DEPTH_LOG2,
   parameter int unsigned WIDTH  = DATA_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/waveform_to_pipe_bram.sv
// Captures one 32-bit sample per simulation tick into a FIFO and streams it to
// the host pipe-out endpoint as 16-bit halfwords, low half first.
// Ports:
//   clk             host-interface clock, all state lives here
//   reset           asynchronous active-high reset
//   sample_tick     simulation tick, asynchronous; rising edge requests a capture
//   capture_en      ticks are ignored while low
//   wave_in         sample value, taken on the internal push cycle
//   pipe_out_read   one halfword consumed per high cycle
//   pipe_out_data   halfword for the read strobed in the previous cycle
//   pipe_out_ready  registered sample_count >= BLOCK_SAMPLES
//   sample_count    whole samples not yet fully read
//   overflow        sticky, a capture was dropped because the FIFO was full
//   underflow       sticky, a read arrived while the FIFO was empty
module waveform_to_pipe_bram
   import waveform_to_pipe_bram_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
   parameter int unsigned BLOCK_SAMPLES = DEFAULT_BLOCK_SAMPLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_tick,
   input  logic                  capture_en,
   input  logic [DATA_W-1:0]     wave_in,
   input  logic                  pipe_out_read,
   output logic [HALF_W-1:0]     pipe_out_data,
   output logic                  pipe_out_ready,
   output logic [DEPTH_LOG2:0]   sample_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(2**DEPTH_LOG2);
   localparam logic [CNT_W-1:0] BLOCK_COUNT = CNT_W'(BLOCK_SAMPLES);

   logic                  tick_meta;
   logic                  tick_sync;
   logic                  tick_prev;
   logic                  push;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  rd_en;
   logic                  rd_done;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  half_sel;
   logic                  out_hi;    // half of ram_q presented on pipe_out_data
   logic                  out_zero;  // force zero output (reset or underflow read)
   logic [DATA_W-1:0]     ram_q;

   assign push    = tick_sync & ~tick_prev;
   assign full    = (sample_count == FULL_COUNT);
   assign empty   = (sample_count == '0);
   assign wr_en   = push & capture_en & ~full;
   assign rd_en   = pipe_out_read & ~empty;
   assign rd_done = rd_en & half_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_meta      <= 1'b0;
         tick_sync      <= 1'b0;
         tick_prev      <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         half_sel       <= 1'b0;
         out_hi         <= 1'b0;
         out_zero       <= 1'b1;
         sample_count   <= '0;
         pipe_out_ready <= 1'b0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         tick_meta <= sample_tick;
         tick_sync <= tick_meta;
         tick_prev <= tick_sync;

         if (wr_en) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (push && capture_en && full) begin
            overflow <= 1'b1;
         end

         if (pipe_out_read) begin
            if (empty) begin
               underflow <= 1'b1;
               out_zero  <= 1'b1;
            end else begin
               out_zero <= 1'b0;
               out_hi   <= half_sel;
               half_sel <= ~half_sel;
               if (half_sel) begin
                  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
               end
            end
         end

         unique case ({wr_en, rd_done})
            2'b10:   sample_count <= sample_count + CNT_W'(1);
            2'b01:   sample_count <= sample_count - CNT_W'(1);
            default: sample_count <= sample_count;
         endcase

         // One cycle behind sample_count by design.
         pipe_out_ready <= (sample_count >= BLOCK_COUNT);
      end
   end

   sdp_bram #(
      .ADDR_W (DEPTH_LOG2),
      .WIDTH  (DATA_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wave_in),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   // RAM output register holds between reads, so the selected half does too.
   always_comb begin
      pipe_out_data = '0;
      if (!out_zero) begin
         pipe_out_data = out_hi ? ram_q[DATA_W-1 -: HALF_W] : ram_q[HALF_W-1:0];
      end
   end

endmodule
